// File: rtl/fp_sign_apply_pkg.sv
// Shared single-precision float definitions.
// Used by fp_sign_apply, fp_classify and fpAbsolute.
package fp_sign_apply_pkg;

    typedef logic [31:0] float32_t;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_MSB = 22;

    localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

    localparam int TUSER_ZERO_BIT = 0;
    localparam int TUSER_NAN_BIT  = 1;

    typedef struct packed {
        logic               sign;
        logic [EXP_MSB:0]   mag;
    } s1_t;

    typedef struct packed {
        float32_t   data;
        logic [1:0] user;
    } s2_t;

    function automatic float32_t fp_with_sign(
        input logic [EXP_MSB:0] mag,
        input logic             sign
    );
        return {sign, mag};
    endfunction

    function automatic float32_t fp_abs(input float32_t x);
        return {1'b0, x[EXP_MSB:0]};
    endfunction

endpackage

// File: rtl/fp_sign_apply_if.sv
// Stream bundle for the sign-apply join: two inputs, one result.
// slave = block side, master = environment side.
interface fp_sign_apply_if;
    import fp_sign_apply_pkg::*;

    float32_t   s_mag_tdata;
    logic       s_mag_tvalid;
    logic       s_mag_tready;

    logic       s_sign_tdata;
    logic       s_sign_tvalid;
    logic       s_sign_tready;

    float32_t   m_result_tdata;
    logic [1:0] m_result_tuser;
    logic       m_result_tvalid;
    logic       m_result_tready;

    modport slave (
        input  s_mag_tdata,
        input  s_mag_tvalid,
        output s_mag_tready,
        input  s_sign_tdata,
        input  s_sign_tvalid,
        output s_sign_tready,
        output m_result_tdata,
        output m_result_tuser,
        output m_result_tvalid,
        input  m_result_tready
    );

    modport master (
        output s_mag_tdata,
        output s_mag_tvalid,
        input  s_mag_tready,
        output s_sign_tdata,
        output s_sign_tvalid,
        input  s_sign_tready,
        input  m_result_tdata,
        input  m_result_tuser,
        input  m_result_tvalid,
        output m_result_tready
    );

endinterface

// File: rtl/fp_classify.sv
// Combinational zero / NaN detection on the unsigned part of a float.
module fp_classify
    import fp_sign_apply_pkg::*;
(
    input  logic [EXP_MSB:0] i_mag,
    output logic             o_is_zero,
    output logic             o_is_nan
);

    logic [EXP_MSB-EXP_LSB:0] w_exp;
    logic [MANT_MSB:0]        w_mant;

    assign w_exp  = i_mag[EXP_MSB:EXP_LSB];
    assign w_mant = i_mag[MANT_MSB:0];

    assign o_is_zero = (i_mag == '0);
    assign o_is_nan  = (w_exp == EXP_ALL_ONES) && (w_mant != '0);

endmodule

// File: rtl/fp_sign_apply.sv
// Joins a magnitude stream with a sign stream and emits the signed float
// through a two-stage valid/ready pipeline, with zero/NaN flags.
module fp_sign_apply
    import fp_sign_apply_pkg::*;
#(
    parameter int FORCE_NAN_POSITIVE = 0,
    parameter int COUNT_WIDTH        = 16
) (
    input  logic                   aclk,
    input  logic                   reset,
    fp_sign_apply_if.slave         bus,
    output logic [COUNT_WIDTH-1:0] xfer_count
);

    logic w_s2_adv;
    logic w_s1_adv;
    logic w_join;

    logic w_is_zero;
    logic w_is_nan;
    logic w_out_sign;

    float32_t w_s1_result;
    logic     w_unused_in_sign;

    logic r_s1_valid;
    s1_t  r_s1;
    logic r_s2_valid;
    s2_t  r_s2;

    logic [COUNT_WIDTH-1:0] r_count;

    // Stage 2 frees when empty or drained; stage 1 rides on that.
    assign w_s2_adv = !r_s2_valid || bus.m_result_tready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;

    assign w_join = bus.s_mag_tvalid && bus.s_sign_tvalid
                 && w_s1_adv && !reset;

    assign bus.s_mag_tready  = w_s1_adv && bus.s_sign_tvalid && !reset;
    assign bus.s_sign_tready = w_s1_adv && bus.s_mag_tvalid && !reset;

    // The incoming sign bit of the magnitude is replaced, never used.
    assign w_unused_in_sign = bus.s_mag_tdata[SIGN_BIT];

    fp_classify u_classify (
        .i_mag     (r_s1.mag),
        .o_is_zero (w_is_zero),
        .o_is_nan  (w_is_nan)
    );

    assign w_out_sign = (FORCE_NAN_POSITIVE != 0 && w_is_nan)
                      ? 1'b0 : r_s1.sign;

    assign w_s1_result = fp_with_sign(r_s1.mag, w_out_sign);

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= w_join;
            end
            if (w_join) begin
                r_s1.sign <= bus.s_sign_tdata;
                r_s1.mag  <= bus.s_mag_tdata[EXP_MSB:0];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2       <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2.data                 <= w_s1_result;
                r_s2.user[TUSER_ZERO_BIT] <= w_is_zero;
                r_s2.user[TUSER_NAN_BIT]  <= w_is_nan;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_join) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign bus.m_result_tvalid = r_s2_valid;
    assign bus.m_result_tdata  = r_s2.data;
    assign bus.m_result_tuser  = r_s2.user;
    assign xfer_count          = r_count;

endmodule

// File: tb/tb_fp_sign_apply.sv
// Directed bench: default instance plus a NaN-positive, 4-bit-counter
// instance fed the identical input streams.
module tb_fp_sign_apply;
    import fp_sign_apply_pkg::*;

    logic aclk = 1'b0;
    logic reset;

    always #5 aclk = ~aclk;

    fp_sign_apply_if bus0 ();
    fp_sign_apply_if bus1 ();

    logic [15:0] cnt0;
    logic [3:0]  cnt1;

    fp_sign_apply dut0 (
        .aclk       (aclk),
        .reset      (reset),
        .bus        (bus0.slave),
        .xfer_count (cnt0)
    );

    fp_sign_apply #(
        .FORCE_NAN_POSITIVE (1),
        .COUNT_WIDTH        (4)
    ) dut1 (
        .aclk       (aclk),
        .reset      (reset),
        .bus        (bus1.slave),
        .xfer_count (cnt1)
    );

    assign bus1.s_mag_tdata     = bus0.s_mag_tdata;
    assign bus1.s_mag_tvalid    = bus0.s_mag_tvalid;
    assign bus1.s_sign_tdata    = bus0.s_sign_tdata;
    assign bus1.s_sign_tvalid   = bus0.s_sign_tvalid;
    assign bus1.m_result_tready = bus0.m_result_tready;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    logic [31:0] v_mag [8] = '{32'h40f8a3d7, 32'hc0f8a3d7, 32'h80000000,
                               32'h00000000, 32'h7fc00000, 32'h7f800000,
                               32'h00000001, 32'hff800001};
    logic        v_sgn [8] = '{1'b1, 1'b0, 1'b1, 1'b0,
                               1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] v_exp0[8] = '{32'hc0f8a3d7, 32'h40f8a3d7, 32'h80000000,
                               32'h00000000, 32'hffc00000, 32'hff800000,
                               32'h80000001, 32'h7f800001};
    logic [31:0] v_exp1[8] = '{32'hc0f8a3d7, 32'h40f8a3d7, 32'h80000000,
                               32'h00000000, 32'h7fc00000, 32'hff800000,
                               32'h80000001, 32'h7f800001};
    logic [1:0]  v_usr [8] = '{2'b00, 2'b00, 2'b01, 2'b01,
                               2'b10, 2'b00, 2'b00, 2'b10};

    logic [31:0] st_mag[4] = '{32'h3f800000, 32'h40000000,
                               32'h40400000, 32'h00000000};
    logic        st_sgn[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] st_exp[4] = '{32'hbf800000, 32'h40000000,
                               32'hc0400000, 32'h80000000};
    logic [1:0]  st_usr[4] = '{2'b00, 2'b00, 2'b00, 2'b01};

    logic [31:0] rx_d[$];
    logic [1:0]  rx_u[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input logic mv, input logic [31:0] m,
                         input logic sv, input logic s);
        bus0.s_mag_tvalid  = mv;
        bus0.s_mag_tdata   = m;
        bus0.s_sign_tvalid = sv;
        bus0.s_sign_tdata  = s;
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_cnt0"}, 32'(cnt0), 32'(exp_cnt % 65536));
        chk({tag, "_cnt1"}, 32'(cnt1), 32'(exp_cnt % 16));
    endtask

    initial begin
        int  idx;
        int  fires;
        logic fire;

        reset = 1'b1;
        bus0.m_result_tready = 1'b1;
        drive(1'b1, 32'h40f8a3d7, 1'b1, 1'b1);
        step();
        step();
        chk("rst_tvalid", 32'(bus0.m_result_tvalid), 32'd0);
        chk("rst_tdata", bus0.m_result_tdata, 32'd0);
        chk("rst_tuser", 32'(bus0.m_result_tuser), 32'd0);
        chk("rst_mag_tready", 32'(bus0.s_mag_tready), 32'd0);
        chk("rst_sign_tready", 32'(bus0.s_sign_tready), 32'd0);
        chk_counts("rst");

        // First low edge joins the held inputs.
        reset = 1'b0;
        step();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        exp_cnt = 1;
        chk_counts("first");
        chk("first_lat1_tvalid", 32'(bus0.m_result_tvalid), 32'd0);
        step();
        chk("first_tvalid", 32'(bus0.m_result_tvalid), 32'd1);
        chk("first_tdata", bus0.m_result_tdata, 32'hc0f8a3d7);
        chk("first_tuser", 32'(bus0.m_result_tuser), 32'd0);

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, v_mag[i], 1'b1, v_sgn[i]);
            #1;
            chk($sformatf("vec%0d_mag_tready", i),
                32'(bus0.s_mag_tready), 32'd1);
            step();
            drive(1'b0, 32'd0, 1'b0, 1'b0);
            step();
            exp_cnt++;
            chk($sformatf("vec%0d_tvalid", i),
                32'(bus0.m_result_tvalid), 32'd1);
            chk($sformatf("vec%0d_data0", i), bus0.m_result_tdata, v_exp0[i]);
            chk($sformatf("vec%0d_user0", i),
                32'(bus0.m_result_tuser), 32'(v_usr[i]));
            chk($sformatf("vec%0d_data1", i), bus1.m_result_tdata, v_exp1[i]);
            chk($sformatf("vec%0d_user1", i),
                32'(bus1.m_result_tuser), 32'(v_usr[i]));
        end
        chk_counts("vec");

        // Back-pressure: four offered, downstream stalled for five edges.
        step();
        bus0.m_result_tready = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (idx == 4 && rx_d.size() == 4) break;
            if (cyc == 5) bus0.m_result_tready = 1'b1;
            if (idx < 4) drive(1'b1, st_mag[idx], 1'b1, st_sgn[idx]);
            else drive(1'b0, 32'd0, 1'b0, 1'b0);
            #1;
            fire = bus0.s_mag_tready && bus0.s_mag_tvalid;
            if (bus0.m_result_tvalid && bus0.m_result_tready) begin
                rx_d.push_back(bus0.m_result_tdata);
                rx_u.push_back(bus0.m_result_tuser);
            end
            if (bus0.m_result_tvalid && !bus0.m_result_tready) begin
                chk($sformatf("stall_hold%0d", cyc),
                    bus0.m_result_tdata, st_exp[0]);
            end
            step();
            if (fire) idx++;
            if (cyc == 4) chk("stall_accepted", 32'(idx), 32'd2);
        end
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        chk("stall_rx_count", 32'(rx_d.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < rx_d.size()) begin
                chk($sformatf("stall_rx%0d_data", i), rx_d[i], st_exp[i]);
                chk($sformatf("stall_rx%0d_user", i),
                    32'(rx_u[i]), 32'(st_usr[i]));
            end
        end
        step();
        chk("stall_no_dup", 32'(bus0.m_result_tvalid), 32'd0);
        exp_cnt += 4;
        chk_counts("stall");

        // Sign arrives early; it must wait for the magnitude.
        drive(1'b0, 32'd0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("early_sign_tready%0d", k),
                32'(bus0.s_sign_tready), 32'd0);
            step();
        end
        chk_counts("early");
        drive(1'b1, 32'h3fc00000, 1'b1, 1'b1);
        #1;
        chk("join_sign_tready", 32'(bus0.s_sign_tready), 32'd1);
        step();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        exp_cnt++;
        chk_counts("join");
        step();
        chk("join_tdata", bus0.m_result_tdata, 32'hbfc00000);
        step();
        chk("join_drained", 32'(bus0.m_result_tvalid), 32'd0);

        // Fill both stages under stall, then reset.
        bus0.m_result_tready = 1'b0;
        drive(1'b1, 32'h41200000, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h41a00000, 1'b1, 1'b1);
        step();
        exp_cnt += 2;
        drive(1'b1, 32'h42c80000, 1'b1, 1'b0);
        #1;
        chk("full_mag_tready", 32'(bus0.s_mag_tready), 32'd0);
        chk("full_tvalid", 32'(bus0.m_result_tvalid), 32'd1);
        chk("full_tdata", bus0.m_result_tdata, 32'h41200000);
        step();
        chk_counts("full");
        reset = 1'b1;
        step();
        exp_cnt = 0;
        chk("midrst_tvalid", 32'(bus0.m_result_tvalid), 32'd0);
        chk("midrst_mag_tready", 32'(bus0.s_mag_tready), 32'd0);
        chk_counts("midrst");
        reset = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        bus0.m_result_tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("post_rst_idle%0d", k),
                32'(bus0.m_result_tvalid), 32'd0);
        end

        // Counter wrap on the 4-bit instance.
        fires = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (fires == 17) break;
            drive(1'b1, 32'h3f800000 + 32'(cyc), 1'b1, 1'b0);
            #1;
            fire = bus0.s_mag_tready;
            step();
            if (fire) fires++;
        end
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        chk("wrap_fires", 32'(fires), 32'd17);
        exp_cnt = 17;
        chk("wrap_cnt0", 32'(cnt0), 32'd17);
        chk("wrap_cnt1", 32'(cnt1), 32'd1);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
